// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: control encoding, BHT counter,
// BHT index helper and the registered result payload.
package branch_resolve_unit_pkg;

    // Condition select driven by decode.
    typedef enum logic [2:0] {
        BR_EQ   = 3'd0,
        BR_NE   = 3'd1,
        BR_LT   = 3'd2,
        BR_GE   = 3'd3,
        BR_LTU  = 3'd4,
        BR_GEU  = 3'd5,
        BR_JUMP = 3'd6,
        BR_NONE = 3'd7
    } BranchResolverCtrl;

    // Widest PC the result payload carries; the top truncates to XLEN (XLEN <= 64).
    localparam int unsigned RESULT_PC_W = 64;

    typedef logic [1:0] bht_counter_t;

    // Weakly not-taken.
    localparam bht_counter_t BHT_INIT_DEFAULT = 2'b01;

    typedef struct packed {
        logic                   isTaken;
        logic                   mispredict;
        logic [RESULT_PC_W-1:0] redirectPc;
    } BranchResult;

    // Word-aligned PC bits select the entry; depth must be a power of two.
    function automatic int unsigned bht_index(input logic [RESULT_PC_W-1:0] pc,
                                              input int unsigned depth);
        logic [RESULT_PC_W-1:0] idx;
        idx = (pc >> 2) & RESULT_PC_W'(depth - 1);
        return 32'(idx);
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Direct-mapped bimodal table of 2-bit saturating counters.
// Combinational lookup port, one training port written at the clock edge;
// a lookup of the entry being trained sees the pre-update value.
module branch_history_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned  XLEN  = 32,
    parameter int unsigned  DEPTH = 64,
    parameter bht_counter_t INIT  = BHT_INIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken_c,
    input  logic            update_en,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bht_counter_t     ctr [DEPTH];
    bht_counter_t     next_ctr;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;

    assign lookup_idx     = IDX_W'(bht_index(RESULT_PC_W'(lookup_pc), DEPTH));
    assign update_idx     = IDX_W'(bht_index(RESULT_PC_W'(update_pc), DEPTH));
    assign lookup_taken_c = ctr[lookup_idx][1];

    // Saturating step of the entry being trained.
    always_comb begin
        next_ctr = ctr[update_idx];
        if (update_taken) begin
            if (ctr[update_idx] != 2'b11) next_ctr = ctr[update_idx] + 2'b01;
        end else begin
            if (ctr[update_idx] != 2'b00) next_ctr = ctr[update_idx] - 2'b01;
        end
    end

    // Counter storage; reset returns every entry to INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr <= '{default: INIT};
        end else if (update_en) begin
            ctr[update_idx] <= next_ctr;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolver: evaluates the condition, computes the real next
// PC, flags mispredictions against fetch, and trains the bimodal BHT.
// Optional macro BRANCH_STATS_EN adds branch / mispredict handshake counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned  XLEN      = 32,
    parameter int unsigned  BHT_DEPTH = 64,
    parameter bht_counter_t BHT_INIT  = BHT_INIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqIsBranch,
    input  BranchResolverCtrl reqBrCtrl,
    input  logic [XLEN-1:0]   reqPc,
    input  logic [XLEN-1:0]   reqRs1Data,
    input  logic [XLEN-1:0]   reqRs2Data,
    input  logic [XLEN-1:0]   reqNpcOp1,
    input  logic [XLEN-1:0]   reqNpcOp2,
    input  logic              reqPredTaken,
    input  logic [XLEN-1:0]   reqPredPc,
    input  logic              flush,
    output logic              resValid,
    input  logic              resReady,
    output logic              resIsTaken,
    output logic              resMispredict,
    output logic [XLEN-1:0]   resRedirectPc,
    input  logic [XLEN-1:0]   bhtLookupPc,
    output logic              bhtLookupTaken
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       statBranchCount,
    output logic [31:0]       statMispredictCount
`endif
);

    logic            accept_c;
    logic            cond_taken_c;
    logic            is_cond_c;
    logic            bht_update_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] fall_c;
    logic [XLEN-1:0] next_pc_c;
    BranchResult     res_d;
    BranchResult     res_q;

    assign reqReady = !resValid || resReady;
    assign accept_c = reqValid && reqReady;

    // Direction of the op; jumps always taken, BR_NONE never.
    always_comb begin
        cond_taken_c = 1'b0;
        case (reqBrCtrl)
            BR_EQ:   cond_taken_c = (reqRs1Data == reqRs2Data);
            BR_NE:   cond_taken_c = (reqRs1Data != reqRs2Data);
            BR_LT:   cond_taken_c = ($signed(reqRs1Data) <  $signed(reqRs2Data));
            BR_GE:   cond_taken_c = ($signed(reqRs1Data) >= $signed(reqRs2Data));
            BR_LTU:  cond_taken_c = (reqRs1Data <  reqRs2Data);
            BR_GEU:  cond_taken_c = (reqRs1Data >= reqRs2Data);
            BR_JUMP: cond_taken_c = 1'b1;
            default: cond_taken_c = 1'b0;
        endcase
    end

    assign is_cond_c    = (reqBrCtrl != BR_JUMP) && (reqBrCtrl != BR_NONE);
    assign target_c     = (reqNpcOp1 + reqNpcOp2) & ~XLEN'(1);
    assign fall_c       = reqPc + XLEN'(4);
    assign next_pc_c    = cond_taken_c ? target_c : fall_c;
    // Training also happens for flushed requests; it only moves a hint.
    assign bht_update_c = accept_c && reqIsBranch && is_cond_c;

    // Result payload; non-branch ops report all zeros.
    always_comb begin
        res_d = '0;
        if (reqIsBranch) begin
            res_d.isTaken    = cond_taken_c;
            res_d.redirectPc = RESULT_PC_W'(next_pc_c);
            res_d.mispredict = (cond_taken_c != reqPredTaken) || (next_pc_c != reqPredPc);
        end
    end

    // Output stage: flush wins over accept, result held under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resValid <= 1'b0;
            res_q    <= '0;
        end else if (flush) begin
            resValid <= 1'b0;
        end else if (accept_c) begin
            resValid <= 1'b1;
            res_q    <= res_d;
        end else if (resReady) begin
            resValid <= 1'b0;
        end
    end

    assign resIsTaken    = res_q.isTaken;
    assign resMispredict = res_q.mispredict;
    assign resRedirectPc = XLEN'(res_q.redirectPc);

    branch_history_table #(
        .XLEN  (XLEN),
        .DEPTH (BHT_DEPTH),
        .INIT  (BHT_INIT)
    ) u_bht (
        .clk            (clk),
        .rst            (rst),
        .lookup_pc      (bhtLookupPc),
        .lookup_taken_c (bhtLookupTaken),
        .update_en      (bht_update_c),
        .update_pc      (reqPc),
        .update_taken   (cond_taken_c)
    );

`ifdef BRANCH_STATS_EN
    logic res_is_branch;

    // Remembers whether the held result came from a branch op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_is_branch <= 1'b0;
        end else if (!flush && accept_c) begin
            res_is_branch <= reqIsBranch;
        end
    end

    // Counts branch results and mispredicts at the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statBranchCount     <= '0;
            statMispredictCount <= '0;
        end else if (resValid && resReady && res_is_branch) begin
            statBranchCount <= statBranchCount + 32'd1;
            if (res_q.mispredict) statMispredictCount <= statMispredictCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (default parameters).
// Expected results are queued when a request is driven and popped when the
// result appears; a bench-side BHT model tracks predicted direction.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic [31:0] pc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              reqValid;
    logic              reqReady;
    logic              reqIsBranch;
    BranchResolverCtrl reqBrCtrl;
    logic [31:0]       reqPc, reqRs1Data, reqRs2Data, reqNpcOp1, reqNpcOp2, reqPredPc;
    logic              reqPredTaken;
    logic              flush;
    logic              resValid;
    logic              resReady;
    logic              resIsTaken;
    logic              resMispredict;
    logic [31:0]       resRedirectPc;
    logic [31:0]       bhtLookupPc;
    logic              bhtLookupTaken;
`ifdef BRANCH_STATS_EN
    logic [31:0]       statBranchCount;
    logic [31:0]       statMispredictCount;
`endif

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_br = 0;
    int          exp_mis = 0;
    logic [1:0]  bht_m [64];

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst            (rst),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqIsBranch    (reqIsBranch),
        .reqBrCtrl      (reqBrCtrl),
        .reqPc          (reqPc),
        .reqRs1Data     (reqRs1Data),
        .reqRs2Data     (reqRs2Data),
        .reqNpcOp1      (reqNpcOp1),
        .reqNpcOp2      (reqNpcOp2),
        .reqPredTaken   (reqPredTaken),
        .reqPredPc      (reqPredPc),
        .flush          (flush),
        .resValid       (resValid),
        .resReady       (resReady),
        .resIsTaken     (resIsTaken),
        .resMispredict  (resMispredict),
        .resRedirectPc  (resRedirectPc),
        .bhtLookupPc    (bhtLookupPc),
        .bhtLookupTaken (bhtLookupTaken)
`ifdef BRANCH_STATS_EN
        ,
        .statBranchCount     (statBranchCount),
        .statMispredictCount (statMispredictCount)
`endif
    );

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    // Reference resolution; signed compare derived from sign bits + unsigned compare.
    function automatic exp_t model(input BranchResolverCtrl c, input logic isb,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] o1,
                                   input logic [31:0] o2, input logic pt,
                                   input logic [31:0] ppc);
        logic lt_u, lt_s, t;
        logic [31:0] nx;
        exp_t e;
        lt_u = (a < b);
        lt_s = (a[31] != b[31]) ? a[31] : lt_u;
        case (c)
            BR_EQ:   t = (a == b);
            BR_NE:   t = (a != b);
            BR_LT:   t = lt_s;
            BR_GE:   t = !lt_s;
            BR_LTU:  t = lt_u;
            BR_GEU:  t = !lt_u;
            BR_JUMP: t = 1'b1;
            default: t = 1'b0;
        endcase
        nx = t ? ((o1 + o2) & 32'hFFFF_FFFE) : (pc + 32'd4);
        if (isb) begin
            e.taken = t;
            e.pc    = nx;
            e.mis   = (t != pt) || (nx != ppc);
        end else begin
            e = '0;
        end
        return e;
    endfunction

    // Drives one request at the falling edge; acc = model expects acceptance,
    // push = result is expected to complete its output handshake.
    task automatic drive_req(input BranchResolverCtrl c, input logic isb,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pc, input logic [31:0] o1,
                             input logic [31:0] o2, input logic pt,
                             input logic [31:0] ppc, input logic fl,
                             input logic acc, input logic push);
        exp_t e;
        @(negedge clk);
        reqValid = 1'b1; reqIsBranch = isb; reqBrCtrl = c;
        reqRs1Data = a; reqRs2Data = b; reqPc = pc;
        reqNpcOp1 = o1; reqNpcOp2 = o2; reqPredTaken = pt; reqPredPc = ppc;
        flush = fl;
        e = model(c, isb, a, b, pc, o1, o2, pt, ppc);
        if (push) begin
            sb.push_back(e);
            if (isb) begin
                exp_br++;
                if (e.mis) exp_mis++;
            end
        end
        if (acc && isb && c != BR_JUMP && c != BR_NONE) begin
            if (e.taken && bht_m[bidx(pc)] != 2'b11) bht_m[bidx(pc)] = bht_m[bidx(pc)] + 2'b01;
            if (!e.taken && bht_m[bidx(pc)] != 2'b00) bht_m[bidx(pc)] = bht_m[bidx(pc)] - 2'b01;
        end
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; reqValid = 1'b0; reqIsBranch = 1'b0; reqBrCtrl = BR_NONE;
        reqPc = '0; reqRs1Data = '0; reqRs2Data = '0; reqNpcOp1 = '0; reqNpcOp2 = '0;
        reqPredTaken = 1'b0; reqPredPc = '0; flush = 1'b0; resReady = 1'b1;
        bhtLookupPc = 32'h40;
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (resValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", resValid); end
        n_chk++; if (resIsTaken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", resIsTaken); end
        n_chk++; if (resMispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %b want 0", resMispredict); end
        n_chk++; if (resRedirectPc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect: got %h want 0", resRedirectPc); end
        n_chk++; if (reqReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", reqReady); end
        n_chk++; if (bhtLookupTaken !== 1'b0) begin n_fail++; $display("FAIL reset_bht: got %b want 0", bhtLookupTaken); end
        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef BRANCH_STATS_EN
        n_chk++; if (statBranchCount !== 32'd0) begin n_fail++; $display("FAIL reset_stat_br: got %0d want 0", statBranchCount); end
        n_chk++; if (statMispredictCount !== 32'd0) begin n_fail++; $display("FAIL reset_stat_mis: got %0d want 0", statMispredictCount); end
`endif
    endtask

    task automatic test_bht();
        exp_t e;
        logic pre_lit;
        resReady = 1'b1;
        bhtLookupPc = 32'h40;
        // Five taken BR_EQ at 0x40: counter 1 -> 2 -> 3 -> 3 -> 3.
        for (int k = 0; k < 5; k++) begin
            pre_lit = (k == 0) ? 1'b0 : 1'b1;
            drive_req(BR_EQ, 1'b1, 32'd5, 32'd5, 32'h40, 32'h40, 32'h10, 1'b1, 32'h50, 1'b0, 1'b1, 1'b1);
            n_chk++; if (bhtLookupTaken !== pre_lit) begin n_fail++; $display("FAIL bht_same_cycle k=%0d: got %b want %b", k, bhtLookupTaken, pre_lit); end
            step();
            if (sb.size() == 0) begin
                n_chk++; n_fail++; $display("FAIL bht_sb_empty: no expected result queued");
            end else begin
                e = sb.pop_front();
                n_chk++; if (resValid !== 1'b1) begin n_fail++; $display("FAIL bht_valid: got %b want 1", resValid); end
                n_chk++; if (resIsTaken !== e.taken) begin n_fail++; $display("FAIL bht_taken: got %b want %b", resIsTaken, e.taken); end
                n_chk++; if (resMispredict !== e.mis) begin n_fail++; $display("FAIL bht_mis: got %b want %b", resMispredict, e.mis); end
                n_chk++; if (resRedirectPc !== e.pc) begin n_fail++; $display("FAIL bht_redirect: got %h want %h", resRedirectPc, e.pc); end
            end
            n_chk++; if (bhtLookupTaken !== 1'b1) begin n_fail++; $display("FAIL bht_after k=%0d: got %b want 1", k, bhtLookupTaken); end
        end
        bhtLookupPc = 32'h140;
        #1;
        n_chk++; if (bhtLookupTaken !== 1'b1) begin n_fail++; $display("FAIL bht_alias_0x140: got %b want 1", bhtLookupTaken); end
        bhtLookupPc = 32'h44;
        #1;
        n_chk++; if (bhtLookupTaken !== 1'b0) begin n_fail++; $display("FAIL bht_neighbor_0x44: got %b want 0", bhtLookupTaken); end
        // Two not-taken at the alias 0x140: 3 -> 2 -> 1 proves saturation held at 3.
        bhtLookupPc = 32'h40;
        for (int k = 0; k < 2; k++) begin
            drive_req(BR_NE, 1'b1, 32'd7, 32'd7, 32'h140, 32'h0, 32'h0, 1'b0, 32'h144, 1'b0, 1'b1, 1'b1);
            step();
            if (sb.size() != 0) e = sb.pop_front();
            n_chk++; if (resRedirectPc !== 32'h144) begin n_fail++; $display("FAIL bht_nt_redirect: got %h want 00000144", resRedirectPc); end
            n_chk++; if (bhtLookupTaken !== bht_m[16][1]) begin n_fail++; $display("FAIL bht_dec k=%0d: got %b want %b", k, bhtLookupTaken, bht_m[16][1]); end
        end
        n_chk++; if (bhtLookupTaken !== 1'b0) begin n_fail++; $display("FAIL bht_final: got %b want 0", bhtLookupTaken); end
    endtask

    task automatic test_conditions();
        exp_t e;
        BranchResolverCtrl c;
        logic isb, pt;
        logic [31:0] a, b, pc, o1, o2, ppc, tg;
        logic [31:0] vals [6];
        logic [2:0] lit_t, lit_m;
        logic [31:0] lit_pc [3];
        vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678};
        lit_t = 3'b001;
        lit_m = 3'b001;
        lit_pc = '{32'h120, 32'h104, 32'h104};
        resReady = 1'b1;
        for (int k = 0; k < 45; k++) begin
            if (k < 3) begin
                isb = 1'b1; pc = 32'h100; o1 = 32'h100; o2 = 32'h20; pt = 1'b0; ppc = 32'h104;
                c = (k == 0) ? BR_LT : ((k == 1) ? BR_LTU : BR_GE);
                a = (k == 2) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                b = (k == 2) ? 32'h0 : 32'h1;
            end else begin
                c   = BranchResolverCtrl'(3'($urandom_range(7, 0)));
                isb = (k == 3) ? 1'b0 : 1'($urandom_range(9, 0) != 0);
                a   = vals[$urandom_range(5, 0)];
                b   = ($urandom_range(3, 0) == 0) ? a : vals[$urandom_range(5, 0)];
                pc  = $urandom & 32'hFFFF_FFFC;
                if (k == 4) pc = 32'hFFFF_FFFC;
                o1  = $urandom;
                o2  = $urandom;
                pt  = 1'($urandom_range(1, 0));
                tg  = (o1 + o2) & 32'hFFFF_FFFE;
                case ($urandom_range(2, 0))
                    0:       ppc = tg;
                    1:       ppc = pc + 32'd4;
                    default: ppc = $urandom;
                endcase
            end
            drive_req(c, isb, a, b, pc, o1, o2, pt, ppc, 1'b0, 1'b1, 1'b1);
            step();
            if (sb.size() == 0) begin
                n_chk++; n_fail++; $display("FAIL cond_sb_empty: no expected result queued");
            end else begin
                e = sb.pop_front();
                n_chk++; if (resValid !== 1'b1) begin n_fail++; $display("FAIL cond_valid k=%0d: got %b want 1", k, resValid); end
                n_chk++; if (resIsTaken !== e.taken) begin n_fail++; $display("FAIL cond_taken k=%0d ctrl=%0d: got %b want %b", k, c, resIsTaken, e.taken); end
                n_chk++; if (resMispredict !== e.mis) begin n_fail++; $display("FAIL cond_mis k=%0d ctrl=%0d: got %b want %b", k, c, resMispredict, e.mis); end
                n_chk++; if (resRedirectPc !== e.pc) begin n_fail++; $display("FAIL cond_redirect k=%0d ctrl=%0d: got %h want %h", k, c, resRedirectPc, e.pc); end
            end
            if (k < 3) begin
                n_chk++; if (resIsTaken !== lit_t[k]) begin n_fail++; $display("FAIL plan_taken k=%0d: got %b want %b", k, resIsTaken, lit_t[k]); end
                n_chk++; if (resMispredict !== lit_m[k]) begin n_fail++; $display("FAIL plan_mis k=%0d: got %b want %b", k, resMispredict, lit_m[k]); end
                n_chk++; if (resRedirectPc !== lit_pc[k]) begin n_fail++; $display("FAIL plan_redirect k=%0d: got %h want %h", k, resRedirectPc, lit_pc[k]); end
            end
            bhtLookupPc = pc;
            #1;
            n_chk++; if (bhtLookupTaken !== bht_m[bidx(pc)][1]) begin n_fail++; $display("FAIL cond_bht k=%0d: got %b want %b", k, bhtLookupTaken, bht_m[bidx(pc)][1]); end
        end
        step();
        n_chk++; if (resValid !== 1'b0) begin n_fail++; $display("FAIL cond_drain: got %b want 0", resValid); end
`ifdef BRANCH_STATS_EN
        n_chk++; if (statBranchCount !== 32'(exp_br)) begin n_fail++; $display("FAIL cond_stat_br: got %0d want %0d", statBranchCount, exp_br); end
        n_chk++; if (statMispredictCount !== 32'(exp_mis)) begin n_fail++; $display("FAIL cond_stat_mis: got %0d want %0d", statMispredictCount, exp_mis); end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t ea, e;
        resReady = 1'b1;
        // A: taken BR_NE, correctly predicted.
        drive_req(BR_NE, 1'b1, 32'd1, 32'd2, 32'h200, 32'h300, 32'h0, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
        step();
        ea = sb.pop_front();
        n_chk++; if (resValid !== 1'b1) begin n_fail++; $display("FAIL bp_a_valid: got %b want 1", resValid); end
        n_chk++; if (resRedirectPc !== 32'h300) begin n_fail++; $display("FAIL bp_a_redirect: got %h want 00000300", resRedirectPc); end
        resReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive_req(BR_GEU, 1'b1, 32'd9, 32'd3, 32'h400, 32'h480, 32'h0, 1'b0, 32'h404, 1'b0, 1'b0, 1'b0);
            else begin @(negedge clk); #1; end
            n_chk++; if (reqReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready i=%0d: got %b want 0", i, reqReady); end
            step();
            n_chk++; if (resValid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid i=%0d: got %b want 1", i, resValid); end
            n_chk++; if (resIsTaken !== ea.taken) begin n_fail++; $display("FAIL bp_hold_taken i=%0d: got %b want %b", i, resIsTaken, ea.taken); end
            n_chk++; if (resMispredict !== ea.mis) begin n_fail++; $display("FAIL bp_hold_mis i=%0d: got %b want %b", i, resMispredict, ea.mis); end
            n_chk++; if (resRedirectPc !== ea.pc) begin n_fail++; $display("FAIL bp_hold_redirect i=%0d: got %h want %h", i, resRedirectPc, ea.pc); end
        end
        // B accepted in the same cycle A is consumed, then C straight after.
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive_req(BR_GEU, 1'b1, 32'd9, 32'd3, 32'h400, 32'h480, 32'h0, 1'b0, 32'h404, 1'b0, 1'b1, 1'b1);
            else        drive_req(BR_JUMP, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h3, 1'b1, 32'h2, 1'b0, 1'b1, 1'b1);
            resReady = 1'b1;
            #1;
            n_chk++; if (reqReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d: got %b want 1", i, reqReady); end
            step();
            if (sb.size() == 0) begin
                n_chk++; n_fail++; $display("FAIL b2b_sb_empty: no expected result queued");
            end else begin
                e = sb.pop_front();
                n_chk++; if (resValid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid i=%0d: got %b want 1", i, resValid); end
                n_chk++; if (resIsTaken !== e.taken) begin n_fail++; $display("FAIL b2b_taken i=%0d: got %b want %b", i, resIsTaken, e.taken); end
                n_chk++; if (resMispredict !== e.mis) begin n_fail++; $display("FAIL b2b_mis i=%0d: got %b want %b", i, resMispredict, e.mis); end
                n_chk++; if (resRedirectPc !== e.pc) begin n_fail++; $display("FAIL b2b_redirect i=%0d: got %h want %h", i, resRedirectPc, e.pc); end
            end
        end
        step();
        n_chk++; if (resValid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", resValid); end
    endtask

    task automatic test_flush();
        resReady = 1'b1;
        // Mispredicting jump flushed in its accept cycle.
        drive_req(BR_JUMP, 1'b1, 32'd0, 32'd0, 32'h500, 32'h600, 32'h0, 1'b0, 32'h504, 1'b1, 1'b1, 1'b0);
        step();
        n_chk++; if (resValid !== 1'b0) begin n_fail++; $display("FAIL flush_accept_valid: got %b want 0", resValid); end
        // Held result killed by a later flush.
        resReady = 1'b0;
        drive_req(BR_LTU, 1'b1, 32'd1, 32'd2, 32'h540, 32'h700, 32'h0, 1'b1, 32'h700, 1'b0, 1'b1, 1'b0);
        step();
        n_chk++; if (resValid !== 1'b1) begin n_fail++; $display("FAIL flush_held_pre: got %b want 1", resValid); end
        @(negedge clk);
        flush = 1'b1;
        step();
        n_chk++; if (resValid !== 1'b0) begin n_fail++; $display("FAIL flush_held_post: got %b want 0", resValid); end
        resReady = 1'b1;
`ifdef BRANCH_STATS_EN
        n_chk++; if (statBranchCount !== 32'(exp_br)) begin n_fail++; $display("FAIL flush_stat_br: got %0d want %0d", statBranchCount, exp_br); end
        n_chk++; if (statMispredictCount !== 32'(exp_mis)) begin n_fail++; $display("FAIL flush_stat_mis: got %0d want %0d", statMispredictCount, exp_mis); end
`endif
    endtask

    task automatic test_async_reset();
        logic pre;
        resReady = 1'b0;
        bhtLookupPc = 32'h80;
        drive_req(BR_EQ, 1'b1, 32'd3, 32'd3, 32'h80, 32'h90, 32'h0, 1'b0, 32'h84, 1'b0, 1'b1, 1'b0);
        step();
        pre = bht_m[bidx(32'h80)][1];
        n_chk++; if (resValid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b want 1", resValid); end
        n_chk++; if (bhtLookupTaken !== pre) begin n_fail++; $display("FAIL arst_pre_bht: got %b want %b", bhtLookupTaken, pre); end
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
        n_chk++; if (resValid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", resValid); end
        n_chk++; if (resRedirectPc !== 32'h0) begin n_fail++; $display("FAIL arst_redirect: got %h want 0", resRedirectPc); end
        n_chk++; if (bhtLookupTaken !== 1'b0) begin n_fail++; $display("FAIL arst_bht: got %b want 0", bhtLookupTaken); end
`ifdef BRANCH_STATS_EN
        n_chk++; if (statBranchCount !== 32'd0) begin n_fail++; $display("FAIL arst_stat_br: got %0d want 0", statBranchCount); end
        n_chk++; if (statMispredictCount !== 32'd0) begin n_fail++; $display("FAIL arst_stat_mis: got %0d want 0", statMispredictCount); end
`endif
        @(negedge clk);
        rst = 1'b0;
        resReady = 1'b1;
        step();
        n_chk++; if (resValid !== 1'b0) begin n_fail++; $display("FAIL arst_after: got %b want 0", resValid); end
    endtask

    initial begin
        test_reset();
        test_bht();
        test_conditions();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
